// File: rtl/hist_div_ctrl_pkg.sv
// hist_pkg: shared constants and the state encoding for hist_div_ctrl.
// Purpose : entry/line geometry of the CDF and scratch memories, the
//           saturation value of an equalisation map entry, and the
//           controller state type.
// Ports   : none (package).
package hist_pkg;

  localparam int ENTRY_W          = 32;
  localparam int PIX_W            = 8;
  localparam int ENTRIES_PER_LINE = 4;
  localparam int LINE_W           = ENTRY_W * ENTRIES_PER_LINE;
  localparam int MAP_MAX          = 255;

  // State encoding values, kept as named constants so other blocks (and
  // debug tooling) can refer to them without the enum type.
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_MIN_RD    = 4'd1;
  localparam logic [3:0] ST_MIN_WAIT  = 4'd2;
  localparam logic [3:0] ST_MIN_CHK   = 4'd3;
  localparam logic [3:0] ST_CALC_DEN  = 4'd4;
  localparam logic [3:0] ST_LINE_RD   = 4'd5;
  localparam logic [3:0] ST_LINE_WAIT = 4'd6;
  localparam logic [3:0] ST_DIV_START = 4'd7;
  localparam logic [3:0] ST_DIV_WAIT  = 4'd8;
  localparam logic [3:0] ST_WRITE     = 4'd9;
  localparam logic [3:0] ST_WT_IDLE1  = 4'd10;
  localparam logic [3:0] ST_WT_IDLE2  = 4'd11;
  localparam logic [3:0] ST_COMPLETE  = 4'd12;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    MIN_RD    = ST_MIN_RD,
    MIN_WAIT  = ST_MIN_WAIT,
    MIN_CHK   = ST_MIN_CHK,
    CALC_DEN  = ST_CALC_DEN,
    LINE_RD   = ST_LINE_RD,
    LINE_WAIT = ST_LINE_WAIT,
    DIV_START = ST_DIV_START,
    DIV_WAIT  = ST_DIV_WAIT,
    WRITE     = ST_WRITE,
    WT_IDLE1  = ST_WT_IDLE1,
    WT_IDLE2  = ST_WT_IDLE2,
    COMPLETE  = ST_COMPLETE
  } state_e;

endpackage

// File: rtl/hist_div_ctrl_seq_div.sv
// seq_div: restoring unsigned divider, one quotient bit per clock.
// Purpose : quot = num / den. Operands are captured on start; done pulses
//           for one cycle DIV_W+1 cycles after the start cycle, with quot
//           valid from that cycle until the next start.
// Ports   : clk, reset (sync, active-high), start (1-cycle pulse),
//           num/den [DIV_W-1:0] in, quot [DIV_W-1:0] out, done out.
module seq_div #(
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] num,
  input  logic [DIV_W-1:0] den,
  output logic [DIV_W-1:0] quot,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W:0]   remShift;
  logic [DIV_W-1:0] remSub;

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // One restoring step per cycle: the quotient register doubles as the
  // dividend shifter, so the next dividend bit is always its MSB.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    den_d    = den_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    remShift = {rem_q, quo_q[DIV_W-1]};
    // Only used when remShift >= den, where the true difference fits DIV_W bits.
    remSub   = remShift[DIV_W-1:0] - den_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = num;
      den_d  = den;
      cnt_d  = CNT_W'(DIV_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (remShift >= {1'b0, den_q}) begin
        rem_d = remSub;
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = remShift[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign quot = quo_q;
  assign done = done_q;

endmodule

// File: rtl/hist_div_ctrl.sv
// hist_div_ctrl: turns a 256-entry CDF into a histogram-equalisation map.
// Purpose : finds cdf_min (first nonzero CDF entry), then for every entry
//           computes ((cdf-cdf_min)*255)/(NUM_PIXELS-cdf_min) with seq_div,
//           packs 4 entries per 128-bit line and writes them to scratch
//           memory, then pulses div_sc_mem_wt_done.
// Config  : define HIST_DIV_ROUND_EN for round-to-nearest (adds den/2 to
//           the numerator); undefined gives truncating division. Timing is
//           identical in both builds.
// Ports   : clk, reset (sync, active-high)
//           cdf_wt_done        in   start pulse (ignored unless idle)
//           cdf_mem_rd_data    in   128b CDF line, entry k at [32k+31:32k]
//           cdf_mem_rd_addr    out  CDF line address (data valid RD_LAT later)
//           div_sc_mem_wt_addr out  scratch line address
//           div_sc_mem_wt_data out  packed map line, entry k at [32k+7:32k]
//           div_sc_mem_wt_en   out  one-cycle scratch write strobe
//           div_sc_mem_wt_done out  one-cycle completion pulse
//           div_InProgress     out  busy flag, start acceptance to done
module hist_div_ctrl
  import hist_pkg::*;
#(
  parameter int NUM_PIXELS = 1024,
  parameter int NUM_LINES  = 64,
  parameter int RD_LAT     = 2,
  parameter int DIV_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cdf_wt_done,
  input  logic [LINE_W-1:0] cdf_mem_rd_data,
  output logic [15:0]       cdf_mem_rd_addr,
  output logic [15:0]       div_sc_mem_wt_addr,
  output logic [LINE_W-1:0] div_sc_mem_wt_data,
  output logic              div_sc_mem_wt_en,
  output logic              div_sc_mem_wt_done,
  output logic              div_InProgress
);

  localparam logic [15:0]      LAST_LINE      = 16'(NUM_LINES - 1);
  localparam logic [3:0]       MIN_WAIT_LAST  = 4'(RD_LAT - 1);
  localparam logic [3:0]       LINE_WAIT_LAST = 4'(RD_LAT);
  localparam logic [DIV_W-1:0] PIX_TOTAL      = DIV_W'(NUM_PIXELS);
  localparam logic [DIV_W-1:0] QUOT_MAX       = DIV_W'(MAP_MAX);
  localparam logic [PIX_W-1:0] MAP_FULL       = PIX_W'(MAP_MAX);

  typedef logic [ENTRIES_PER_LINE-1:0][DIV_W-1:0] cdf_line_t;
  typedef logic [ENTRIES_PER_LINE-1:0][PIX_W-1:0] map_line_t;

  state_e           state_q, state_d;
  logic [15:0]      line_q, line_d;
  logic [3:0]       wait_q, wait_d;
  logic [1:0]       slot_q, slot_d;
  logic [DIV_W-1:0] cdfMin_q, cdfMin_d;
  logic [DIV_W-1:0] den_q, den_d;
  cdf_line_t        lineCdf_q, lineCdf_d;
  map_line_t        map_q, map_d;
  logic [15:0]      rdAddr_q, rdAddr_d;
  logic [15:0]      wtAddr_q, wtAddr_d;
  logic [LINE_W-1:0] wtData_q, wtData_d;
  logic             wtEn_q, wtEn_d;
  logic             done_q, done_d;
  logic             inProg_q, inProg_d;

  cdf_line_t        rdEntries;
  logic             minFound;
  logic [DIV_W-1:0] minVal;
  logic [DIV_W-1:0] curCdf;
  logic [DIV_W-1:0] diff;
  logic [DIV_W-1:0] numRaw;
  logic [DIV_W-1:0] numDiv;
  logic [PIX_W-1:0] quotClamp;
  logic [LINE_W-1:0] packedLine;
  state_e           afterSlot;
  logic             divStart;
  logic [DIV_W-1:0] divQuot;
  logic             divDone;

  seq_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (divStart),
    .num   (numDiv),
    .den   (den_q),
    .quot  (divQuot),
    .done  (divDone)
  );

  // Controller and output registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      line_q    <= '0;
      wait_q    <= '0;
      slot_q    <= '0;
      cdfMin_q  <= '0;
      den_q     <= '0;
      lineCdf_q <= '0;
      map_q     <= '0;
      rdAddr_q  <= '0;
      wtAddr_q  <= '0;
      wtData_q  <= '0;
      wtEn_q    <= 1'b0;
      done_q    <= 1'b0;
      inProg_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      wait_q    <= wait_d;
      slot_q    <= slot_d;
      cdfMin_q  <= cdfMin_d;
      den_q     <= den_d;
      lineCdf_q <= lineCdf_d;
      map_q     <= map_d;
      rdAddr_q  <= rdAddr_d;
      wtAddr_q  <= wtAddr_d;
      wtData_q  <= wtData_d;
      wtEn_q    <= wtEn_d;
      done_q    <= done_d;
      inProg_q  <= inProg_d;
    end
  end

  // Datapath helpers: line unpacking, first-nonzero search, numerator
  // formation and quotient saturation.
  always_comb begin
    rdEntries = '0;
    minFound  = 1'b0;
    minVal    = '0;
    // Scan high to low so the lowest nonzero slot wins.
    for (int k = ENTRIES_PER_LINE - 1; k >= 0; k--) begin
      rdEntries[k] = cdf_mem_rd_data[k*ENTRY_W +: DIV_W];
      if (cdf_mem_rd_data[k*ENTRY_W +: ENTRY_W] != '0) begin
        minFound = 1'b1;
        minVal   = cdf_mem_rd_data[k*ENTRY_W +: DIV_W];
      end
    end
    curCdf = lineCdf_q[slot_q];
    diff   = curCdf - cdfMin_q;
    // x*255 as (x<<8)-x; entries below cdf_min map to zero.
    numRaw = (curCdf >= cdfMin_q) ? ((diff << 8) - diff) : '0;
`ifdef HIST_DIV_ROUND_EN
    numDiv = numRaw + (den_q >> 1);
`else
    numDiv = numRaw;
`endif
    quotClamp = (divQuot > QUOT_MAX) ? MAP_FULL : divQuot[PIX_W-1:0];
    packedLine = '0;
    for (int k = 0; k < ENTRIES_PER_LINE; k++) begin
      packedLine[k*ENTRY_W +: ENTRY_W] = ENTRY_W'(map_q[k]);
    end
    afterSlot = (slot_q == 2'd3) ? WRITE : DIV_START;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    wait_d    = wait_q;
    slot_d    = slot_q;
    cdfMin_d  = cdfMin_q;
    den_d     = den_q;
    lineCdf_d = lineCdf_q;
    map_d     = map_q;
    rdAddr_d  = rdAddr_q;
    wtAddr_d  = wtAddr_q;
    wtData_d  = wtData_q;
    wtEn_d    = 1'b0;
    done_d    = 1'b0;
    inProg_d  = inProg_q;
    divStart  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cdf_wt_done) begin
          inProg_d = 1'b1;
          line_d   = '0;
          state_d  = MIN_RD;
        end
      end
      MIN_RD: begin
        rdAddr_d = line_q;
        wait_d   = '0;
        state_d  = MIN_WAIT;
      end
      MIN_WAIT: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == MIN_WAIT_LAST) state_d = MIN_CHK;
      end
      MIN_CHK: begin
        if (minFound) begin
          cdfMin_d = minVal;
          state_d  = CALC_DEN;
        end else if (line_q == LAST_LINE) begin
          // All-zero CDF: force den to zero so every entry maps to 0.
          cdfMin_d = PIX_TOTAL;
          state_d  = CALC_DEN;
        end else begin
          line_d  = line_q + 16'd1;
          state_d = MIN_RD;
        end
      end
      CALC_DEN: begin
        den_d   = PIX_TOTAL - cdfMin_q;
        line_d  = '0;
        state_d = LINE_RD;
      end
      LINE_RD: begin
        rdAddr_d = line_q;
        wait_d   = '0;
        state_d  = LINE_WAIT;
      end
      LINE_WAIT: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == LINE_WAIT_LAST) begin
          lineCdf_d = rdEntries;
          slot_d    = '0;
          state_d   = DIV_START;
        end
      end
      DIV_START: begin
        // Degenerate cases resolve in one cycle without the divider.
        if (den_q == '0) begin
          map_d[slot_q] = (curCdf != '0) ? MAP_FULL : '0;
          slot_d        = slot_q + 2'd1;
          state_d       = afterSlot;
        end else if (numRaw == '0) begin
          map_d[slot_q] = '0;
          slot_d        = slot_q + 2'd1;
          state_d       = afterSlot;
        end else begin
          divStart = 1'b1;
          state_d  = DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        if (divDone) begin
          map_d[slot_q] = quotClamp;
          slot_d        = slot_q + 2'd1;
          state_d       = afterSlot;
        end
      end
      WRITE: begin
        wtEn_d   = 1'b1;
        wtAddr_d = line_q;
        wtData_d = packedLine;
        state_d  = WT_IDLE1;
      end
      WT_IDLE1: state_d = WT_IDLE2;
      WT_IDLE2: begin
        if (line_q == LAST_LINE) begin
          state_d = COMPLETE;
        end else begin
          line_d  = line_q + 16'd1;
          state_d = LINE_RD;
        end
      end
      COMPLETE: begin
        done_d   = 1'b1;
        inProg_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cdf_mem_rd_addr    = rdAddr_q;
  assign div_sc_mem_wt_addr = wtAddr_q;
  assign div_sc_mem_wt_data = wtData_q;
  assign div_sc_mem_wt_en   = wtEn_q;
  assign div_sc_mem_wt_done = done_q;
  assign div_InProgress     = inProg_q;

endmodule

// File: tb/tb_hist_div_ctrl.sv
// tb_hist_div_ctrl: self-checking bench for hist_div_ctrl.
// Models the CDF memory (2-cycle read latency) and the scratch memory,
// runs several CDF scenarios, checks hand-computed table entries plus a
// full-table reference model, and exercises restart/reset corner cases.
// Honours HIST_DIV_ROUND_EN for the rounding-dependent expectations.
module tb_hist_div_ctrl;

  logic         clk;
  logic         reset;
  logic         cdf_wt_done;
  logic [127:0] cdf_mem_rd_data;
  logic [15:0]  cdf_mem_rd_addr;
  logic [15:0]  div_sc_mem_wt_addr;
  logic [127:0] div_sc_mem_wt_data;
  logic         div_sc_mem_wt_en;
  logic         div_sc_mem_wt_done;
  logic         div_InProgress;

  hist_div_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .cdf_wt_done        (cdf_wt_done),
    .cdf_mem_rd_data    (cdf_mem_rd_data),
    .cdf_mem_rd_addr    (cdf_mem_rd_addr),
    .div_sc_mem_wt_addr (div_sc_mem_wt_addr),
    .div_sc_mem_wt_data (div_sc_mem_wt_data),
    .div_sc_mem_wt_en   (div_sc_mem_wt_en),
    .div_sc_mem_wt_done (div_sc_mem_wt_done),
    .div_InProgress     (div_InProgress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           cdfMem [0:255];
  logic [127:0] scratch [0:63];
  logic [15:0]  addrLog [0:1023];
  logic [127:0] rdPipe;
  int           wtCount;
  int           doneCount;
  int           divStarts;
  int           testsRun;
  int           testsFailed;

  typedef struct {
    int scen;
    int idx;
    int expMap;
  } vec_t;
  vec_t vecs [0:12];

  function automatic logic [127:0] packLine(input logic [5:0] ln);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'(cdfMem[{ln, 2'(k)}]);
    return l;
  endfunction

  // CDF memory: data appears two clocks after the address changes.
  always @(posedge clk) begin
    rdPipe          <= packLine(cdf_mem_rd_addr[5:0]);
    cdf_mem_rd_data <= rdPipe;
  end

  // Scratch memory and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (div_sc_mem_wt_en) begin
      scratch[div_sc_mem_wt_addr[5:0]] <= div_sc_mem_wt_data;
      addrLog[wtCount & 1023]          <= div_sc_mem_wt_addr;
      wtCount                          <= wtCount + 1;
    end
    if (div_sc_mem_wt_done) doneCount <= doneCount + 1;
    if (dut.divStart) divStarts <= divStarts + 1;
  end

  function automatic logic [31:0] scratchEntry(input int idx);
    logic [127:0] l;
    l = scratch[idx >> 2];
    return l[(idx & 3)*32 +: 32];
  endfunction

  function automatic int modelMin();
    for (int i = 0; i < 256; i++) if (cdfMem[i] != 0) return cdfMem[i];
    return 1024;
  endfunction

  function automatic int modelMap(input int c, input int mn);
    int den;
    int num;
    int q;
    den = 1024 - mn;
    if (den == 0) return (c != 0) ? 255 : 0;
    if (c < mn) return 0;
    num = (c - mn) * 255;
    if (num == 0) return 0;
`ifdef HIST_DIV_ROUND_EN
    num = num + den / 2;
`endif
    q = num / den;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    cdf_wt_done = 1'b1;
    @(negedge clk);
    cdf_wt_done = 1'b0;
  endtask

  task automatic loadCdf(input int scen);
    for (int i = 0; i < 256; i++) begin
      case (scen)
        0:       cdfMem[i] = 4 * (i + 1);
        1:       cdfMem[i] = (i < 100) ? 0 : 1024;
        2:       cdfMem[i] = (i < 255) ? 512 : 1024;
        default: cdfMem[i] = (i == 0) ? 1 : ((i == 1) ? 4 : 1024);
      endcase
    end
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (div_sc_mem_wt_done) seen = 1'b1;
    end
    checkOutput("doneSeen", 128'(seen), 128'd1);
    checkOutput("inProgressAtDone", 128'(div_InProgress), 128'd0);
  endtask

  task automatic runScenario(input int scen, input bit rePulse, output int starts);
    int wt0;
    int dn0;
    int ds0;
    int errs;
    int mn;
    loadCdf(scen);
    @(negedge clk);
    wt0 = wtCount;
    dn0 = doneCount;
    ds0 = divStarts;
    applyStimulus();
    repeat (5) @(negedge clk);
    checkOutput("inProgressRunning", 128'(div_InProgress), 128'd1);
    if (rePulse) begin
      repeat (300) @(negedge clk);
      applyStimulus();
    end
    waitDone();
    @(negedge clk);
    checkOutput("donePulseWidth", 128'(div_sc_mem_wt_done), 128'd0);
    repeat (100) @(negedge clk);
    checkOutput("wtCount", 128'(wtCount - wt0), 128'd64);
    checkOutput("doneCount", 128'(doneCount - dn0), 128'd1);
    checkOutput("idleAfterDone", 128'(div_InProgress), 128'd0);
    errs = 0;
    for (int k = 0; k < 64; k++) if (addrLog[(wt0 + k) & 1023] !== 16'(k)) errs++;
    checkOutput("wrAddrOrder", 128'(errs), 128'd0);
    mn = modelMin();
    for (int i = 0; i < 256; i++)
      checkOutput($sformatf("model map[%0d] scen%0d", i, scen),
                  128'(scratchEntry(i)), 128'(modelMap(cdfMem[i], mn)));
    for (int v = 0; v < 13; v++)
      if (vecs[v].scen == scen)
        checkOutput($sformatf("vec map[%0d] scen%0d", vecs[v].idx, scen),
                    128'(scratchEntry(vecs[v].idx)), 128'(vecs[v].expMap));
    starts = divStarts - ds0;
  endtask

  initial begin
    int starts;
    bit hit;
    int dn0;
    vecs[0]  = '{0, 0, 0};
    vecs[1]  = '{0, 5, 5};
    vecs[2]  = '{0, 100, 100};
    vecs[3]  = '{0, 255, 255};
    vecs[4]  = '{1, 0, 0};
    vecs[5]  = '{1, 99, 0};
    vecs[6]  = '{1, 100, 255};
    vecs[7]  = '{2, 0, 0};
    vecs[8]  = '{2, 254, 0};
    vecs[9]  = '{2, 255, 255};
    vecs[10] = '{3, 0, 0};
`ifdef HIST_DIV_ROUND_EN
    vecs[11] = '{3, 1, 1};
`else
    vecs[11] = '{3, 1, 0};
`endif
    vecs[12] = '{3, 2, 255};

    reset       = 1'b1;
    cdf_wt_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst rdAddr", 128'(cdf_mem_rd_addr), 128'd0);
    checkOutput("rst wtEn", 128'(div_sc_mem_wt_en), 128'd0);
    checkOutput("rst done", 128'(div_sc_mem_wt_done), 128'd0);
    checkOutput("rst inProgress", 128'(div_InProgress), 128'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] linear CDF");
    runScenario(0, 1'b0, starts);
    checkOutput("line5", scratch[5], 128'h00000017_00000016_00000015_00000014);
    checkOutput("divStarts linear", 128'(starts), 128'd255);

    $display("[TB] constant image");
    runScenario(1, 1'b0, starts);
    checkOutput("divStarts constant", 128'(starts), 128'd0);

    $display("[TB] two-level image with re-pulsed start");
    runScenario(2, 1'b1, starts);
    checkOutput("divStarts twoLevel", 128'(starts), 128'd1);

    $display("[TB] small cdf_min");
    runScenario(3, 1'b0, starts);

    $display("[TB] reset during line 30");
    loadCdf(0);
    applyStimulus();
    hit = 1'b0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk);
      if (div_sc_mem_wt_en && div_sc_mem_wt_addr == 16'd29) hit = 1'b1;
    end
    checkOutput("reachLine29", 128'(hit), 128'd1);
    repeat (20) @(negedge clk);
    dn0   = doneCount;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort rdAddr", 128'(cdf_mem_rd_addr), 128'd0);
    checkOutput("abort wtAddr", 128'(div_sc_mem_wt_addr), 128'd0);
    checkOutput("abort wtData", div_sc_mem_wt_data, 128'd0);
    checkOutput("abort wtEn", 128'(div_sc_mem_wt_en), 128'd0);
    checkOutput("abort done", 128'(div_sc_mem_wt_done), 128'd0);
    checkOutput("abort inProgress", 128'(div_InProgress), 128'd0);
    reset = 1'b0;
    repeat (4000) @(negedge clk);
    checkOutput("noDoneAfterAbort", 128'(doneCount - dn0), 128'd0);
    checkOutput("idleAfterAbort", 128'(div_InProgress), 128'd0);

    $display("[TB] full run after abort");
    runScenario(2, 1'b0, starts);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
